// File: rtl/viterbi_traceback8.sv
// viterbi_traceback8
// -----------------------------------------------------------------------------
// Survivor memory and flush-mode traceback for the 8-state Viterbi decoder.
// One 8-bit ACS decision vector is stored per trellis step. When a packet
// ends, the block starts from the minimum-metric state chosen by the min
// selector. It walks the stored decisions backwards and emits one decoded bit
// per cycle, newest step first. Each bit is tagged with its step index.
//
// Trellis convention:
//   next state of s on input u        = {u, s[2:1]}
//   predecessor of s with decision d  = {s[1:0], d}
//   decoded bit at a step             = MSB of the state at that step
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   dec_valid  in   decision vector valid this cycle
//   dec_bits   in   [7:0] ACS decisions, bit s = survivor choice for state s
//   dec_last   in   final trellis step of the packet (qualified by dec_valid)
//   best_idx   in   [2:0] minimum path-metric state, sampled on the last step
//   in_ready   out  high while step vectors are accepted
//   out_valid  out  decoded bit valid
//   out_bit    out  decoded information bit
//   out_idx    out  [AW-1:0] trellis step index of out_bit (0 = first step)
//   done       out  one-cycle pulse after the final decoded bit
//   ovf        out  sticky: the packet filled the memory without dec_last;
//                   cleared by the next packet's first accepted step
// -----------------------------------------------------------------------------
module viterbi_traceback8 #(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          dec_valid,
    input  logic [7:0]    dec_bits,
    input  logic          dec_last,
    input  logic [2:0]    best_idx,
    output logic          in_ready,
    output logic          out_valid,
    output logic          out_bit,
    output logic [AW-1:0] out_idx,
    output logic          done,
    output logic          ovf
);

    localparam int DEPTH = 2 ** AW;
    localparam logic [AW-1:0] WP_MAX = {AW{1'b1}};

    typedef enum logic [1:0] {
        COLLECT,
        TRACE,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [2:0]    tb_state_q, tb_state_d;
    logic          out_valid_q, out_valid_d;
    logic          out_bit_q, out_bit_d;
    logic [AW-1:0] out_idx_q, out_idx_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;

    // Survivor memory: written once per accepted step and read
    // combinationally during traceback. It is not reset.
    logic [7:0]    mem_q [DEPTH];
    logic          mem_we;
    logic [7:0]    rd_word;
    logic          accept;

    assign in_ready = (state_q == COLLECT);
    assign accept   = dec_valid && in_ready;
    assign rd_word  = mem_q[rd_q];

    // Next-state and output logic. The outputs are registered, so a bit
    // computed here in TRACE is presented the cycle after.
    always_comb begin
        state_d     = state_q;
        wp_d        = wp_q;
        rd_d        = rd_q;
        tb_state_d  = tb_state_q;
        out_valid_d = 1'b0;
        out_bit_d   = out_bit_q;
        out_idx_d   = out_idx_q;
        done_d      = 1'b0;
        ovf_d       = ovf_q;
        mem_we      = 1'b0;

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    mem_we = 1'b1;
                    // A new packet starts at address 0, so the previous
                    // packet's overflow flag is retired here.
                    if (wp_q == '0) begin
                        ovf_d = 1'b0;
                    end
                    if (dec_last || (wp_q == WP_MAX)) begin
                        tb_state_d = best_idx;
                        rd_d       = wp_q;
                        state_d    = TRACE;
                        // The memory is full but the packet is not finished.
                        // Trace what we have and flag the truncation.
                        if (!dec_last) begin
                            ovf_d = 1'b1;
                        end
                    end else begin
                        wp_d = wp_q + AW'(1);
                    end
                end
            end

            TRACE: begin
                out_valid_d = 1'b1;
                out_bit_d   = tb_state_q[2];
                out_idx_d   = rd_q;
                // Step to the predecessor state using the stored decision
                // for the current state at this step.
                tb_state_d  = {tb_state_q[1:0], rd_word[tb_state_q]};
                if (rd_q == '0) begin
                    state_d = DONE;
                end else begin
                    rd_d = rd_q - AW'(1);
                end
            end

            DONE: begin
                done_d  = 1'b1;
                wp_d    = '0;
                state_d = COLLECT;
            end

            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            wp_q        <= '0;
            rd_q        <= '0;
            tb_state_q  <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_idx_q   <= '0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wp_q        <= wp_d;
            rd_q        <= rd_d;
            tb_state_q  <= tb_state_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_idx_q   <= out_idx_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
        end
    end

    // Survivor memory write port.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wp_q] <= dec_bits;
        end
    end

    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign out_idx   = out_idx_q;
    assign done      = done_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_viterbi_traceback8.sv
// tb_viterbi_traceback8
// -----------------------------------------------------------------------------
// Self-checking bench for viterbi_traceback8, built with AW=3 so that an
// overflow packet is only 8 steps long. A packet-level model records the
// decision vectors of each packet. When the packet ends, the model computes
// the whole expected output timeline: one cycle of latency, N decoded bits
// with indices N-1..0, and then the done cycle. Every cycle the DUT outputs
// are compared against the head of that timeline.
// -----------------------------------------------------------------------------
module tb_viterbi_traceback8;

    localparam int AW = 3;
    localparam int DEPTH = 2 ** AW;

    logic          clk;
    logic          rst_n;
    logic          dec_valid;
    logic [7:0]    dec_bits;
    logic          dec_last;
    logic [2:0]    best_idx;
    logic          in_ready;
    logic          out_valid;
    logic          out_bit;
    logic [AW-1:0] out_idx;
    logic          done;
    logic          ovf;

    viterbi_traceback8 #(.AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dec_valid (dec_valid),
        .dec_bits  (dec_bits),
        .dec_last  (dec_last),
        .best_idx  (best_idx),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .out_idx   (out_idx),
        .done      (done),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One expected cycle of DUT outputs.
    typedef struct packed {
        logic          v;
        logic          b;
        logic [AW-1:0] idx;
        logic          d;
        logic          r;
    } exp_t;

    exp_t       sched[$];
    logic [7:0] pkt_dec [DEPTH];
    int         pkt_cnt;
    logic       model_ovf;
    logic       exp_ready_now;
    logic       obs_bit[$];
    int         obs_idx[$];
    int         vectors;
    int         miscompares;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare this cycle's DUT outputs with the head of the expected
    // timeline. When nothing is pending, the block must be idle and ready.
    task automatic checkOutput();
        exp_t e;
        if (sched.size() > 0) begin
            e = sched.pop_front();
        end else begin
            e = '{v: 1'b0, b: 1'b0, idx: '0, d: 1'b0, r: 1'b1};
        end
        exp_ready_now = e.r;
        chk("in_ready", 32'(in_ready), 32'(e.r));
        chk("out_valid", 32'(out_valid), 32'(e.v));
        chk("done", 32'(done), 32'(e.d));
        chk("ovf", 32'(ovf), 32'(model_ovf));
        if (e.v) begin
            chk("out_bit", 32'(out_bit), 32'(e.b));
            chk("out_idx", 32'(out_idx), 32'(e.idx));
            if (out_valid) begin
                obs_bit.push_back(out_bit);
                obs_idx.push_back(int'(out_idx));
            end
        end
    endtask

    // Packet model: collect accepted steps. At the end of the packet, trace
    // back from best_idx with the rule s <- {s[1:0], dec[k][s]}. Emit the
    // MSB of the state at each step, from the newest step to the oldest.
    task automatic modelAccept();
        int   n;
        logic [2:0] s;
        if (!(rst_n && dec_valid && exp_ready_now)) return;
        if (pkt_cnt == 0) model_ovf = 1'b0;
        pkt_dec[pkt_cnt] = dec_bits;
        if (dec_last || pkt_cnt == DEPTH - 1) begin
            if (!dec_last) model_ovf = 1'b1;
            n = pkt_cnt + 1;
            s = best_idx;
            sched.push_back('{v: 1'b0, b: 1'b0, idx: '0, d: 1'b0, r: 1'b0});
            for (int k = n - 1; k >= 0; k--) begin
                sched.push_back('{v: 1'b1, b: s[2], idx: AW'(k), d: 1'b0, r: 1'b0});
                s = {s[1:0], pkt_dec[k][s]};
            end
            sched.push_back('{v: 1'b0, b: 1'b0, idx: '0, d: 1'b1, r: 1'b1});
            pkt_cnt = 0;
        end else begin
            pkt_cnt++;
        end
    endtask

    // One clock cycle: check outputs at the falling edge, drive new inputs,
    // then let the model see what the rising edge accepts.
    task automatic applyStimulus(input logic v, input logic [7:0] bits,
                                 input logic last, input logic [2:0] best);
        @(negedge clk);
        checkOutput();
        dec_valid = v;
        dec_bits  = bits;
        dec_last  = last;
        best_idx  = best;
        @(posedge clk);
        modelAccept();
    endtask

    task automatic idle();
        applyStimulus(1'b0, 8'h00, 1'b0, 3'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sched.size() > 0; i++) idle();
        chk("drain_timeline_empty", 32'(sched.size()), 32'd0);
        idle();
    endtask

    // Pin the model: compare the observed bits of one packet against
    // expectations worked out by hand. Bit k of 'bits' is the bit at step k.
    task automatic checkLiteral(input string name, input int base, input int n,
                                input logic [7:0] bits);
        chk({name, "_count"}, 32'(obs_bit.size() - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < obs_bit.size()) begin
                chk({name, "_idx"}, 32'(obs_idx[base + i]), 32'(n - 1 - i));
                chk({name, "_bit"}, 32'(obs_bit[base + i]), 32'(bits[n - 1 - i]));
            end
        end
    endtask

    task automatic clearModel();
        sched.delete();
        pkt_cnt       = 0;
        model_ovf     = 1'b0;
        exp_ready_now = 1'b1;
    endtask

    initial begin
        int base;
        logic [7:0] seq5 [5];
        vectors     = 0;
        miscompares = 0;
        dec_valid   = 1'b0;
        dec_bits    = 8'h00;
        dec_last    = 1'b0;
        best_idx    = 3'd0;
        rst_n       = 1'b0;
        clearModel();

        // Reset state is checked by the idle timeline while reset is held.
        repeat (3) idle();
        #2 rst_n = 1'b1;
        idle();

        // Test 1: four all-zero steps, best state 0.
        $display("[TB] four-step zero packet");
        base = obs_bit.size();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h00, i == 3, 3'd0);
        drain();
        checkLiteral("zero4", base, 4, 8'h00);

        // Test 2: three steps with one nonzero decision, best state 3'b101.
        $display("[TB] three-step packet");
        base = obs_bit.size();
        applyStimulus(1'b1, 8'h00, 1'b0, 3'd0);
        applyStimulus(1'b1, 8'h00, 1'b0, 3'd0);
        applyStimulus(1'b1, 8'h20, 1'b1, 3'b101);
        drain();
        checkLiteral("three", base, 3, 8'b0000_0101);
        chk("three_ovf", 32'(ovf), 32'd0);

        // Test 3: a single-step packet decodes to best_idx[2].
        $display("[TB] single-step packet");
        base = obs_bit.size();
        applyStimulus(1'b1, 8'h5A, 1'b1, 3'b100);
        drain();
        checkLiteral("single", base, 1, 8'h01);

        // Test 4: the memory fills without dec_last, which sets overflow.
        // best_idx is only meaningful on the final step.
        $display("[TB] overflow packet");
        base = obs_bit.size();
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'hFF, 1'b0, (i == DEPTH - 1) ? 3'b111 : 3'b000);
        drain();
        checkLiteral("ovf8", base, 8, 8'hFF);
        chk("ovf_sticky", 32'(ovf), 32'd1);

        // Test 5: inputs arriving during traceback are ignored. The first
        // accept of the next packet clears ovf.
        $display("[TB] ignore input during traceback");
        applyStimulus(1'b1, 8'h81, 1'b0, 3'd0);
        #1 chk("ovf_cleared", 32'(ovf), 32'd0);
        applyStimulus(1'b1, 8'h42, 1'b1, 3'b011);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'($urandom), 1'b0, 3'($urandom_range(0, 7)));
        drain();
        seq5[0] = 8'h3C; seq5[1] = 8'hA5; seq5[2] = 8'h5A; seq5[3] = 8'hC3; seq5[4] = 8'h96;
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, seq5[i], i == 4, 3'b010);
        drain();

        // Test 6: reset during traceback, after two bits have come out.
        $display("[TB] reset during traceback");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'hE7, i == 3, 3'b110);
        idle();
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        clearModel();
        idle();
        #2 rst_n = 1'b1;
        idle();
        base = obs_bit.size();
        applyStimulus(1'b1, 8'h00, 1'b0, 3'd0);
        applyStimulus(1'b1, 8'h00, 1'b1, 3'b110);
        drain();
        checkLiteral("after_rst", base, 2, 8'b0000_0011);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
